// File: rtl/slice_window_dma.sv
`default_nettype none
// ============================================================================
// slice_window_dma : responder for the slice controller's window/column fetch.
// Optional SLICE_DMA_STATS_EN adds the readCount port.       Revision: 1.0
// ============================================================================
module slice_window_dma #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 16,
   parameter  int MAX_K  = 5,
   localparam int IDX_W  = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
   input  logic              clk,
   input  logic              resetState,
   input  logic              loadWindow,
   input  logic              readNextCol,
   input  logic [ADDR_W-1:0] windowBase,
   input  logic [ADDR_W-1:0] rowStride,
   input  logic [2:0]        filterSize,
   output logic              ramReadEn,
   output logic [ADDR_W-1:0] ramAddr,
   input  logic [DATA_W-1:0] ramDataIn,
   output logic              winWrEn,
   output logic [IDX_W-1:0]  winRow,
   output logic [IDX_W-1:0]  winCol,
   output logic [DATA_W-1:0] winData,
   output logic              dmaAFinish,
   output logic              busy
`ifdef SLICE_DMA_STATS_EN
   ,
   output logic [15:0]       readCount
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WIN_RD = 3'd1,
      COL_RD = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] rowBase_q, rowBase_d;
   logic [ADDR_W-1:0] colPtr_q, colPtr_d;
   logic [2:0]        k_q, k_d;
   logic [IDX_W-1:0]  rowPtr_q, rowPtr_d;
   logic [IDX_W-1:0]  colIdx_q, colIdx_d;
   logic              wrEn_q, wrEn_d;
   logic [IDX_W-1:0]  wrRow_q, wrRow_d;
   logic [IDX_W-1:0]  wrCol_q, wrCol_d;

   logic [2:0]        w_kClamp;
   logic [IDX_W-1:0]  w_kLast;
   logic [ADDR_W-1:0] w_colOff;

   assign w_kClamp = (filterSize > 3'(MAX_K)) ? 3'(MAX_K) : filterSize;
   assign w_kLast  = IDX_W'(k_q - 3'd1);
   // Row base is accumulated per row; only the column offset is added here.
   assign w_colOff = (state_q == COL_RD) ? colPtr_q : ADDR_W'(colIdx_q);

`ifdef SLICE_DMA_STATS_EN
   logic [15:0] readCount_q, readCount_d;
   assign readCount = readCount_q;
`endif

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      stride_d   = stride_q;
      rowBase_d  = rowBase_q;
      colPtr_d   = colPtr_q;
      k_d        = k_q;
      rowPtr_d   = rowPtr_q;
      colIdx_d   = colIdx_q;
      wrEn_d     = 1'b0;
      wrRow_d    = '0;
      wrCol_d    = '0;
      ramReadEn  = 1'b0;
      ramAddr    = '0;
      busy       = 1'b0;
      dmaAFinish = 1'b0;
`ifdef SLICE_DMA_STATS_EN
      readCount_d = readCount_q;
`endif
      case (state_q)
         IDLE: begin
            if (loadWindow || readNextCol) begin
               stride_d = rowStride;
               k_d      = w_kClamp;
               rowPtr_d = '0;
               colIdx_d = '0;
               if (loadWindow) begin
                  base_d    = windowBase;
                  rowBase_d = windowBase;
                  state_d   = (w_kClamp == 3'd0) ? DONE : WIN_RD;
`ifdef SLICE_DMA_STATS_EN
                  readCount_d = '0;
`endif
               end else begin
                  rowBase_d = base_q;
                  state_d   = (w_kClamp == 3'd0) ? DONE : COL_RD;
               end
            end
         end
         WIN_RD: begin
            busy      = 1'b1;
            ramReadEn = 1'b1;
            ramAddr   = rowBase_q + w_colOff;
            wrEn_d    = 1'b1;
            wrRow_d   = rowPtr_q;
            wrCol_d   = colIdx_q;
            if (colIdx_q == w_kLast) begin
               colIdx_d  = '0;
               rowPtr_d  = rowPtr_q + IDX_W'(1);
               rowBase_d = rowBase_q + stride_q;
               if (rowPtr_q == w_kLast) begin
                  state_d  = DRAIN;
                  colPtr_d = ADDR_W'(k_q);
               end
            end else begin
               colIdx_d = colIdx_q + IDX_W'(1);
            end
         end
         COL_RD: begin
            busy      = 1'b1;
            ramReadEn = 1'b1;
            ramAddr   = rowBase_q + w_colOff;
            wrEn_d    = 1'b1;
            wrRow_d   = rowPtr_q;
            // Consumer has already shifted; the new column always lands rightmost.
            wrCol_d   = w_kLast;
            rowPtr_d  = rowPtr_q + IDX_W'(1);
            rowBase_d = rowBase_q + stride_q;
            if (rowPtr_q == w_kLast) begin
               state_d  = DRAIN;
               colPtr_d = colPtr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            dmaAFinish = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef SLICE_DMA_STATS_EN
      if (ramReadEn && (readCount_q != 16'hFFFF)) begin
         readCount_d = readCount_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk or posedge resetState) begin
      if (resetState) begin
         state_q   <= IDLE;
         base_q    <= '0;
         stride_q  <= '0;
         rowBase_q <= '0;
         colPtr_q  <= '0;
         k_q       <= '0;
         rowPtr_q  <= '0;
         colIdx_q  <= '0;
         wrEn_q    <= 1'b0;
         wrRow_q   <= '0;
         wrCol_q   <= '0;
`ifdef SLICE_DMA_STATS_EN
         readCount_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         stride_q  <= stride_d;
         rowBase_q <= rowBase_d;
         colPtr_q  <= colPtr_d;
         k_q       <= k_d;
         rowPtr_q  <= rowPtr_d;
         colIdx_q  <= colIdx_d;
         wrEn_q    <= wrEn_d;
         wrRow_q   <= wrRow_d;
         wrCol_q   <= wrCol_d;
`ifdef SLICE_DMA_STATS_EN
         readCount_q <= readCount_d;
`endif
      end
   end

   assign winWrEn = wrEn_q;
   assign winRow  = wrRow_q;
   assign winCol  = wrCol_q;
   assign winData = wrEn_q ? ramDataIn : '0;

endmodule
`default_nettype wire

// File: tb/tb_slice_window_dma.sv
`default_nettype none
// ============================================================================
// tb_slice_window_dma : scoreboard bench for slice_window_dma.
// Revision: 1.0
// ============================================================================
module tb_slice_window_dma;

   logic        clk = 1'b0;
   logic        resetState;
   logic        loadWindow;
   logic        readNextCol;
   logic [15:0] windowBase;
   logic [15:0] rowStride;
   logic [2:0]  filterSize;
   logic        ramReadEn;
   logic [15:0] ramAddr;
   logic [15:0] ramDataIn = 16'h0;
   logic        winWrEn;
   logic [2:0]  winRow;
   logic [2:0]  winCol;
   logic [15:0] winData;
   logic        dmaAFinish;
   logic        busy;
`ifdef SLICE_DMA_STATS_EN
   logic [15:0] readCount;
`endif

   slice_window_dma #(.DATA_W(16), .ADDR_W(16), .MAX_K(5)) dut (
      .clk         (clk),
      .resetState  (resetState),
      .loadWindow  (loadWindow),
      .readNextCol (readNextCol),
      .windowBase  (windowBase),
      .rowStride   (rowStride),
      .filterSize  (filterSize),
      .ramReadEn   (ramReadEn),
      .ramAddr     (ramAddr),
      .ramDataIn   (ramDataIn),
      .winWrEn     (winWrEn),
      .winRow      (winRow),
      .winCol      (winCol),
      .winData     (winData),
      .dmaAFinish  (dmaAFinish),
      .busy        (busy)
`ifdef SLICE_DMA_STATS_EN
      ,
      .readCount   (readCount)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: data one cycle after the read strobe, content derived from address.
   always @(posedge clk) if (ramReadEn) ramDataIn <= ramAddr ^ 16'hA5A5;

   typedef struct { int cyc; logic [15:0] addr; } rd_t;
   typedef struct { int cyc; int row; int col; logic [15:0] data; } wr_t;
   rd_t rd_q[$];
   wr_t wr_q[$];
   int  fin_q[$];

   int  compared   = 0;
   int  mismatched = 0;
   int  exp_busy   = -1;
   int  exp_rc     = -1;
   bit  final_chk  = 1'b0;
   bit  final_done = 1'b0;
   int  m_base     = 0;
   int  m_colptr   = 0;

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   always @(negedge clk) begin
      rd_t er;
      wr_t ew;
      int  ef;
      if (resetState) begin
         compared++;
         if (ramReadEn || winWrEn || dmaAFinish || busy || ramAddr != 0 ||
             winRow != 0 || winCol != 0 || winData != 0) begin
            mismatched++;
            $display("FAIL reset_outputs: rd=%b wr=%b fin=%b busy=%b addr=%h row=%0d col=%0d data=%h, required all 0",
                     ramReadEn, winWrEn, dmaAFinish, busy, ramAddr, winRow, winCol, winData);
         end
      end else begin
         if (ramReadEn) begin
            compared++;
            if (rd_q.size() == 0) begin
               mismatched++;
               $display("FAIL rd_unexpected: cyc=%0d addr=%h, required no read", cyc, ramAddr);
            end else begin
               er = rd_q.pop_front();
               if (er.cyc != cyc || er.addr !== ramAddr) begin
                  mismatched++;
                  $display("FAIL rd_addr: got cyc=%0d addr=%h, required cyc=%0d addr=%h",
                           cyc, ramAddr, er.cyc, er.addr);
               end
            end
         end
         if (winWrEn) begin
            compared++;
            if (wr_q.size() == 0) begin
               mismatched++;
               $display("FAIL wr_unexpected: cyc=%0d row=%0d col=%0d, required no write", cyc, winRow, winCol);
            end else begin
               ew = wr_q.pop_front();
               if (ew.cyc != cyc || int'(winRow) != ew.row || int'(winCol) != ew.col || winData !== ew.data) begin
                  mismatched++;
                  $display("FAIL wr_data: got cyc=%0d (%0d,%0d) data=%h, required cyc=%0d (%0d,%0d) data=%h",
                           cyc, winRow, winCol, winData, ew.cyc, ew.row, ew.col, ew.data);
               end
            end
         end
         if (dmaAFinish) begin
            compared++;
            if (fin_q.size() == 0) begin
               mismatched++;
               $display("FAIL fin_unexpected: cyc=%0d, required no dmaAFinish", cyc);
            end else begin
               ef = fin_q.pop_front();
               if (ef != cyc) begin
                  mismatched++;
                  $display("FAIL fin_cycle: got cyc=%0d, required cyc=%0d", cyc, ef);
               end
            end
         end
         if (exp_busy >= 0) begin
            compared++;
            if (busy !== (exp_busy != 0)) begin
               mismatched++;
               $display("FAIL busy: cyc=%0d got %b, required %0d", cyc, busy, exp_busy);
            end
         end
`ifdef SLICE_DMA_STATS_EN
         if (exp_rc >= 0) begin
            compared++;
            if (int'(readCount) != exp_rc) begin
               mismatched++;
               $display("FAIL read_count: got %0d, required %0d", readCount, exp_rc);
            end
         end
`endif
      end
      if (final_chk && !final_done) begin
         final_done = 1'b1;
         compared++;
         if (rd_q.size() != 0 || wr_q.size() != 0 || fin_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: reads=%0d writes=%0d finishes=%0d outstanding, required 0",
                     rd_q.size(), wr_q.size(), fin_q.size());
         end
      end
   end

   // Issues one request and pushes every read/write/finish it must produce.
   task automatic do_req(input bit lw, input bit rn, input logic [15:0] base,
                         input logic [15:0] stride, input logic [2:0] fs, input int stray_at);
      int k, n, c, idx;
      logic [15:0] a;
      k = (fs > 3'd5) ? 5 : int'(fs);
      @(negedge clk);
      c = cyc;
      loadWindow  = lw;
      readNextCol = rn;
      windowBase  = base;
      rowStride   = stride;
      filterSize  = fs;
      idx = 0;
      if (lw) begin
         m_base = int'(base);
         for (int r = 0; r < k; r++) begin
            for (int cc = 0; cc < k; cc++) begin
               a = 16'(int'(base) + r * int'(stride) + cc);
               rd_q.push_back('{c + 1 + idx, a});
               wr_q.push_back('{c + 2 + idx, r, cc, a ^ 16'hA5A5});
               idx++;
            end
         end
         if (k > 0) m_colptr = k;
         n = k * k;
      end else begin
         for (int r = 0; r < k; r++) begin
            a = 16'(m_base + r * int'(stride) + m_colptr);
            rd_q.push_back('{c + 1 + r, a});
            wr_q.push_back('{c + 2 + r, r, k - 1, a ^ 16'hA5A5});
         end
         if (k > 0) m_colptr = (m_colptr + 1) & 16'hFFFF;
         n = k;
      end
      fin_q.push_back((n == 0) ? c + 1 : c + n + 2);
      for (int step = 1; step <= n + 3; step++) begin
         @(posedge clk);
         #1;
         if (step == 1) begin
            loadWindow  = 1'b0;
            readNextCol = 1'b0;
         end
         if (step == stray_at) begin
            loadWindow = 1'b1;
            windowBase = 16'h7777;
         end
         if (step == stray_at + 1) loadWindow = 1'b0;
         exp_busy = (n > 0 && step <= n + 1) ? 1 : 0;
      end
   endtask

   task automatic check_rc(input int v);
      @(posedge clk);
      #1;
      exp_rc = v;
      @(posedge clk);
      #1;
      exp_rc = -1;
   endtask

   initial begin
      logic [15:0] a;
      resetState  = 1'b1;
      loadWindow  = 1'b0;
      readNextCol = 1'b0;
      windowBase  = '0;
      rowStride   = '0;
      filterSize  = '0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      resetState = 1'b0;
      exp_busy   = 0;

      // Column before any window: base 0, colPtr 0.
      do_req(1'b0, 1'b1, 16'h0000, 16'd10, 3'd2, 0);
      // K=3 window with a stray loadWindow while busy.
      do_req(1'b1, 1'b0, 16'h0100, 16'd32, 3'd3, 3);
      do_req(1'b0, 1'b1, 16'h0000, 16'd32, 3'd3, 0);
      do_req(1'b0, 1'b1, 16'h0000, 16'd32, 3'd3, 0);
      check_rc(15);
      // Simultaneous requests: window only.
      do_req(1'b1, 1'b1, 16'h0200, 16'd8, 3'd2, 0);
      check_rc(4);
      do_req(1'b1, 1'b0, 16'h0300, 16'd4, 3'd0, 0);
      do_req(1'b0, 1'b1, 16'h0000, 16'd4, 3'd0, 0);
      // K=7 clamps to 5.
      do_req(1'b1, 1'b0, 16'h0400, 16'd5, 3'd7, 0);
      do_req(1'b1, 1'b0, 16'hFFFF, 16'd1, 3'd2, 0);

      // Reset in cycle 5 of a K=5 window: only the first reads/writes occur.
      @(negedge clk);
      begin
         int c;
         c = cyc;
         loadWindow = 1'b1;
         windowBase = 16'h0500;
         rowStride  = 16'd64;
         filterSize = 3'd5;
         for (int i = 0; i < 4; i++) begin
            a = 16'h0500 + 16'(i);
            rd_q.push_back('{c + 1 + i, a});
            if (i < 3) wr_q.push_back('{c + 2 + i, 0, i, a ^ 16'hA5A5});
         end
         for (int step = 1; step <= 4; step++) begin
            @(posedge clk);
            #1;
            loadWindow = 1'b0;
            exp_busy   = 1;
         end
         @(posedge clk);
         #1;
         resetState = 1'b1;
         exp_busy   = -1;
         @(posedge clk);
         #1;
         resetState = 1'b0;
         exp_busy   = 0;
         m_base     = 0;
         m_colptr   = 0;
         repeat (4) @(posedge clk);
      end
      do_req(1'b1, 1'b0, 16'h0040, 16'd3, 3'd1, 0);
      do_req(1'b0, 1'b1, 16'h0000, 16'd3, 3'd1, 0);

      repeat (3) @(posedge clk);
      #1;
      final_chk = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
